m68k_bus_responder: RTL and testbench



---
 rtl/m68k_bus_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_m68k_bus_responder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : m68k_bus_responder                                            |
// | Purpose  : Bus-side responder for the fx68k core. Decodes each CPU bus   |
// |            cycle to block RAM, a handshaked IO port, an autovectored     |
// |            interrupt acknowledge (VPAn) or a bus error (BERRn), and      |
// |            drives the registered DTACKn/BERRn/VPAn handshakes.           |
// | Ports    : clk, reset          - clock, synchronous active-high reset    |
// |            cpu_*               - fx68k strobes, FC, address, data        |
// |            dtack_n/berr_n/vpa_n- registered active-low handshakes        |
// |            ram_*               - sync-read block RAM port, byte enables  |
// |            io_*                - one-clock req / one-clock ack IO port   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module m68k_bus_responder #(
   parameter int ADDR_BITS  = 14,
   parameter int RAM_WAIT   = 1,
   parameter int IO_TIMEOUT = 63
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_as_n,
   input  logic                 cpu_uds_n,
   input  logic                 cpu_lds_n,
   input  logic                 cpu_rw,
   input  logic [2:0]           cpu_fc,
   input  logic [23:1]          cpu_a,
   input  logic [15:0]          cpu_dout,
   output logic [15:0]          cpu_din,
   output logic                 dtack_n,
   output logic                 berr_n,
   output logic                 vpa_n,
   output logic [ADDR_BITS-1:0] ram_addr,
   output logic [1:0]           ram_we,
   output logic [15:0]          ram_wdata,
   input  logic [15:0]          ram_rdata,
   output logic                 io_req,
   output logic                 io_we,
   output logic [1:0]           io_be,
   output logic [6:0]           io_addr,
   output logic [15:0]          io_wdata,
   input  logic [15:0]          io_rdata,
   input  logic                 io_ack
);

   generate
      if (RAM_WAIT < 1 || RAM_WAIT > 15) begin : g_bad_ram_wait
         $error("m68k_bus_responder: RAM_WAIT must be in 1..15");
      end
      if (IO_TIMEOUT < 1 || IO_TIMEOUT > 255) begin : g_bad_io_timeout
         $error("m68k_bus_responder: IO_TIMEOUT must be in 1..255");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAM  = 2'd1,
      ST_IO   = 2'd2,
      ST_TERM = 2'd3
   } state_t;

   localparam logic [7:0] RAM_WAIT_C = 8'(RAM_WAIT);
   localparam logic [7:0] IO_LAST_C  = 8'(IO_TIMEOUT - 1);

   state_t                state, state_nx;
   logic [7:0]            cnt, cnt_nx;
   logic                  is_read, is_read_nx;
   // VPA and unmapped cycles enter TERM with their handshake still pending,
   // so the handshake lands one edge after E0 like the other targets.
   logic                  pend, pend_nx;
   logic                  pend_vpa, pend_vpa_nx;
   logic [15:0]           cpu_din_nx;
   logic                  dtack_n_nx, berr_n_nx, vpa_n_nx;
   logic [ADDR_BITS-1:0]  ram_addr_nx;
   logic [1:0]            ram_we_nx;
   logic [15:0]           ram_wdata_nx;
   logic                  io_req_nx, io_we_nx;
   logic [1:0]            io_be_nx;
   logic [6:0]            io_addr_nx;
   logic [15:0]           io_wdata_nx;

   logic                  start;
   logic                  term_exit;
   logic [1:0]            lanes;
   logic                  unused_addr;

   assign start       = ~cpu_as_n & (~cpu_uds_n | ~cpu_lds_n);
   // Strobes both high with AS still low is the TAS read-to-write gap.
   assign term_exit   = cpu_as_n | (cpu_uds_n & cpu_lds_n);
   assign lanes       = {~cpu_uds_n, ~cpu_lds_n};
   // Upper RAM-region bits are don't-care: RAM mirrors across its 1 MB region.
   assign unused_addr = ^cpu_a;

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      is_read_nx   = is_read;
      pend_nx      = pend;
      pend_vpa_nx  = pend_vpa;
      cpu_din_nx   = cpu_din;
      dtack_n_nx   = dtack_n;
      berr_n_nx    = berr_n;
      vpa_n_nx     = vpa_n;
      ram_addr_nx  = ram_addr;
      ram_we_nx    = 2'b00;
      ram_wdata_nx = ram_wdata;
      io_req_nx    = 1'b0;
      io_we_nx     = io_we;
      io_be_nx     = io_be;
      io_addr_nx   = io_addr;
      io_wdata_nx  = io_wdata;

      case (state)
         ST_IDLE: begin
            if (start) begin
               is_read_nx = cpu_rw;
               cnt_nx     = 8'd0;
               if (cpu_fc == 3'b111) begin
                  state_nx    = ST_TERM;
                  pend_nx     = 1'b1;
                  pend_vpa_nx = 1'b1;
               end else if (cpu_a[23:20] == 4'h0) begin
                  state_nx     = ST_RAM;
                  cnt_nx       = RAM_WAIT_C;
                  ram_addr_nx  = cpu_a[ADDR_BITS:1];
                  ram_wdata_nx = cpu_dout;
                  if (!cpu_rw) begin
                     ram_we_nx = lanes;
                  end
               end else if (cpu_a[23:16] == 8'hFF) begin
                  state_nx    = ST_IO;
                  io_req_nx   = 1'b1;
                  io_we_nx    = ~cpu_rw;
                  io_be_nx    = lanes;
                  io_addr_nx  = cpu_a[7:1];
                  io_wdata_nx = cpu_dout;
               end else begin
                  state_nx    = ST_TERM;
                  pend_nx     = 1'b1;
                  pend_vpa_nx = 1'b0;
               end
            end
         end

         ST_RAM: begin
            if (cpu_as_n) begin
               state_nx = ST_IDLE;
            end else if (cnt == 8'd0) begin
               state_nx   = ST_TERM;
               dtack_n_nx = 1'b0;
               if (is_read) begin
                  cpu_din_nx = ram_rdata;
               end
            end else begin
               cnt_nx = cnt - 8'd1;
            end
         end

         ST_IO: begin
            if (cpu_as_n) begin
               state_nx = ST_IDLE;
               io_we_nx = 1'b0;
               io_be_nx = 2'b00;
            end else if (io_ack) begin
               // Ack is checked before timeout so a coincident ack wins.
               state_nx   = ST_TERM;
               dtack_n_nx = 1'b0;
               io_we_nx   = 1'b0;
               io_be_nx   = 2'b00;
               if (is_read) begin
                  cpu_din_nx = io_rdata;
               end
            end else if (cnt == IO_LAST_C) begin
               state_nx  = ST_TERM;
               berr_n_nx = 1'b0;
               io_we_nx  = 1'b0;
               io_be_nx  = 2'b00;
            end else if (cnt != 8'hFF) begin
               cnt_nx = cnt + 8'd1;
            end
         end

         ST_TERM: begin
            if (pend) begin
               pend_nx = 1'b0;
               if (cpu_as_n) begin
                  state_nx = ST_IDLE;
               end else if (pend_vpa) begin
                  vpa_n_nx = 1'b0;
               end else begin
                  berr_n_nx = 1'b0;
               end
            end else if (term_exit) begin
               state_nx   = ST_IDLE;
               dtack_n_nx = 1'b1;
               berr_n_nx  = 1'b1;
               vpa_n_nx   = 1'b1;
            end
         end

         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= 8'd0;
         is_read   <= 1'b0;
         pend      <= 1'b0;
         pend_vpa  <= 1'b0;
         cpu_din   <= 16'h0000;
         dtack_n   <= 1'b1;
         berr_n    <= 1'b1;
         vpa_n     <= 1'b1;
         ram_addr  <= '0;
         ram_we    <= 2'b00;
         ram_wdata <= 16'h0000;
         io_req    <= 1'b0;
         io_we     <= 1'b0;
         io_be     <= 2'b00;
         io_addr   <= 7'd0;
         io_wdata  <= 16'h0000;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         is_read   <= is_read_nx;
         pend      <= pend_nx;
         pend_vpa  <= pend_vpa_nx;
         cpu_din   <= cpu_din_nx;
         dtack_n   <= dtack_n_nx;
         berr_n    <= berr_n_nx;
         vpa_n     <= vpa_n_nx;
         ram_addr  <= ram_addr_nx;
         ram_we    <= ram_we_nx;
         ram_wdata <= ram_wdata_nx;
         io_req    <= io_req_nx;
         io_we     <= io_we_nx;
         io_be     <= io_be_nx;
         io_addr   <= io_addr_nx;
         io_wdata  <= io_wdata_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_m68k_bus_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_m68k_bus_responder                                         |
// | Purpose  : Self-checking bench for m68k_bus_responder: table of single   |
// |            bus transactions plus TAS, abort and reset-in-TERM sequences. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_m68k_bus_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw;
   logic [2:0]  cpu_fc;
   logic [23:1] cpu_a;
   logic [15:0] cpu_dout;
   logic [15:0] cpu_din;
   logic        dtack_n, berr_n, vpa_n;
   logic [13:0] ram_addr;
   logic [1:0]  ram_we;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic        io_req, io_we;
   logic [1:0]  io_be;
   logic [6:0]  io_addr;
   logic [15:0] io_wdata, io_rdata;
   logic        io_ack;

   always #5 clk = ~clk;

   m68k_bus_responder #(.ADDR_BITS(14), .RAM_WAIT(1), .IO_TIMEOUT(63)) dut (
      .clk(clk), .reset(reset),
      .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n),
      .cpu_rw(cpu_rw), .cpu_fc(cpu_fc), .cpu_a(cpu_a), .cpu_dout(cpu_dout),
      .cpu_din(cpu_din), .dtack_n(dtack_n), .berr_n(berr_n), .vpa_n(vpa_n),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .io_req(io_req), .io_we(io_we), .io_be(io_be),
      .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
      .io_ack(io_ack)
   );

   // Synchronous-read RAM model with byte enables and a preload port.
   logic [15:0] mem [0:16383];
   logic        load_en;
   logic [13:0] load_addr;
   logic [15:0] load_data;

   always @(posedge clk) begin
      if (load_en) begin
         mem[load_addr] <= load_data;
      end else begin
         if (ram_we[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
         if (ram_we[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
      end
      ram_rdata <= mem[ram_addr];
   end

   // Count cycles with a RAM write enable or an IO request visible.
   int we_cycles  = 0;
   int req_cycles = 0;
   always @(negedge clk) begin
      if (ram_we != 2'b00) we_cycles  <= we_cycles + 1;
      if (io_req)          req_cycles <= req_cycles + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [13:0] a, input logic [15:0] d);
      load_addr = a;
      load_data = d;
      load_en   = 1'b1;
      tick();
      load_en   = 1'b0;
   endtask

   // exp_hs: 0 = DTACK, 1 = BERR, 2 = VPA.  tgt: 0 = RAM, 1 = IO, 2 = none.
   typedef struct {
      logic [23:0] addr;
      logic [2:0]  fc;
      logic        rw;
      logic        uds_n;
      logic        lds_n;
      logic [15:0] wdata;
      int          ack_edge;
      logic [15:0] io_rdata;
      logic        late_ack;
      int          exp_hs;
      int          exp_lat;
      logic [15:0] exp_din;
      int          exp_we;
      int          exp_req;
      int          tgt;
      logic [1:0]  exp_ram_we;
      logic [15:0] exp_addr;
      logic        exp_io_we;
      logic [1:0]  exp_io_be;
   } vec_t;

   vec_t vecs [10];

   task automatic run_vec(input int idx);
      vec_t        v;
      int          we0, req0, lat, k;
      logic [2:0]  exp_vec, hs;
      logic [15:0] din_hold;
      v    = vecs[idx];
      we0  = we_cycles;
      req0 = req_cycles;
      case (v.exp_hs)
         0:       exp_vec = 3'b011;
         1:       exp_vec = 3'b101;
         default: exp_vec = 3'b110;
      endcase
      cpu_a     = v.addr[23:1];
      cpu_fc    = v.fc;
      cpu_rw    = v.rw;
      cpu_dout  = v.wdata;
      cpu_uds_n = v.uds_n;
      cpu_lds_n = v.lds_n;
      cpu_as_n  = 1'b0;
      tick();                                   // E0
      if (v.tgt == 0) begin
         check($sformatf("v%0d.ram_addr", idx), 32'(ram_addr), 32'(v.exp_addr[13:0]));
         check($sformatf("v%0d.ram_we", idx), 32'(ram_we), 32'(v.exp_ram_we));
      end else if (v.tgt == 1) begin
         check($sformatf("v%0d.io_addr", idx), 32'(io_addr), 32'(v.exp_addr[6:0]));
         check($sformatf("v%0d.io_we", idx), 32'(io_we), 32'(v.exp_io_we));
         check($sformatf("v%0d.io_be", idx), 32'(io_be), 32'(v.exp_io_be));
         check($sformatf("v%0d.io_wdata", idx), 32'(io_wdata), 32'(v.wdata));
      end
      lat = 0;
      k   = 1;
      hs  = 3'b111;
      while (lat == 0 && k <= 200) begin
         io_ack   = (v.ack_edge == k);
         io_rdata = v.io_rdata;
         tick();
         io_ack   = 1'b0;
         hs = {dtack_n, berr_n, vpa_n};
         if (hs != 3'b111) lat = k;
         k++;
      end
      check($sformatf("v%0d.handshake", idx), 32'(hs), 32'(exp_vec));
      check($sformatf("v%0d.latency", idx), 32'(lat), 32'(v.exp_lat));
      check($sformatf("v%0d.cpu_din", idx), 32'(cpu_din), 32'(v.exp_din));
      if (v.late_ack) begin
         din_hold = cpu_din;
         io_ack   = 1'b1;
         io_rdata = 16'h7777;
         tick();
         io_ack   = 1'b0;
         check($sformatf("v%0d.late_ack_hs", idx), 32'({dtack_n, berr_n, vpa_n}), 32'(exp_vec));
         check($sformatf("v%0d.late_ack_din", idx), 32'(cpu_din), 32'(din_hold));
      end
      cpu_as_n  = 1'b1;
      cpu_uds_n = 1'b1;
      cpu_lds_n = 1'b1;
      tick();
      check($sformatf("v%0d.release", idx), 32'({dtack_n, berr_n, vpa_n}), 32'(3'b111));
      tick();
      check($sformatf("v%0d.ram_we_cycles", idx), 32'(we_cycles - we0), 32'(v.exp_we));
      check($sformatf("v%0d.io_req_cycles", idx), 32'(req_cycles - req0), 32'(v.exp_req));
   endtask

   initial begin
      int we0, req0;
      //            addr        fc    rw    uds   lds   wdata     ack io_rdata late hs lat din       we req tgt ram_we addr      iowe iobe
      vecs[0] = '{24'h000100, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 1'b1, 0, 2, 16'h1234, 0, 0, 0, 2'b00, 16'h0080, 1'b0, 2'b00};
      vecs[1] = '{24'h000102, 3'd5, 1'b0, 1'b0, 1'b1, 16'hABCD, 0, 16'h0000, 1'b0, 0, 2, 16'h1234, 1, 0, 0, 2'b10, 16'h0081, 1'b0, 2'b00};
      vecs[2] = '{24'h000102, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 0, 2, 16'hAB78, 0, 0, 0, 2'b00, 16'h0081, 1'b0, 2'b00};
      vecs[3] = '{24'h008100, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 0, 2, 16'h1234, 0, 0, 0, 2'b00, 16'h0080, 1'b0, 2'b00};
      vecs[4] = '{24'hFF0010, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 6, 16'h5A5A, 1'b0, 0, 6, 16'h5A5A, 0, 1, 1, 2'b00, 16'h0008, 1'b0, 2'b11};
      vecs[5] = '{24'hFF00FE, 3'd5, 1'b0, 1'b1, 1'b0, 16'h00EE, 2, 16'h1111, 1'b0, 0, 2, 16'h5A5A, 0, 1, 1, 2'b00, 16'h007F, 1'b1, 2'b01};
      vecs[6] = '{24'h400000, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 1, 1, 16'h5A5A, 0, 0, 2, 2'b00, 16'h0000, 1'b0, 2'b00};
      vecs[7] = '{24'hFFFFF2, 3'd7, 1'b1, 1'b1, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 2, 1, 16'h5A5A, 0, 0, 2, 2'b00, 16'h0000, 1'b0, 2'b00};
      vecs[8] = '{24'hFF0040, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 1'b1, 1, 63, 16'h5A5A, 0, 1, 1, 2'b00, 16'h0020, 1'b0, 2'b11};
      vecs[9] = '{24'h000100, 3'd7, 1'b0, 1'b0, 1'b0, 16'hDEAD, 0, 16'h0000, 1'b0, 2, 1, 16'h5A5A, 0, 0, 2, 2'b00, 16'h0000, 1'b0, 2'b00};

      reset     = 1'b1;
      cpu_as_n  = 1'b1;
      cpu_uds_n = 1'b1;
      cpu_lds_n = 1'b1;
      cpu_rw    = 1'b1;
      cpu_fc    = 3'd0;
      cpu_a     = '0;
      cpu_dout  = 16'h0000;
      io_ack    = 1'b0;
      io_rdata  = 16'h0000;
      load_en   = 1'b0;
      load_addr = 14'd0;
      load_data = 16'h0000;
      repeat (3) tick();
      load(14'h080, 16'h1234);
      load(14'h081, 16'h5678);
      load(14'h100, 16'h00C3);

      check("reset.handshakes", 32'({dtack_n, berr_n, vpa_n}), 32'(3'b111));
      check("reset.cpu_din", 32'(cpu_din), 32'h0);
      check("reset.ram_we_io_req", 32'({ram_we, io_req, io_we, io_be}), 32'h0);
      check("reset.addrs", 32'({ram_addr, io_addr}), 32'h0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 10; i++) run_vec(i);

      // Abort: AS rises while the IO access waits; a later ack is ignored.
      req0      = req_cycles;
      cpu_a     = 23'h7F8010;                   // byte address 0xFF0020
      cpu_fc    = 3'd5;
      cpu_rw    = 1'b1;
      cpu_uds_n = 1'b0;
      cpu_lds_n = 1'b0;
      cpu_as_n  = 1'b0;
      tick();                                   // E0
      tick();                                   // E0+1
      cpu_as_n  = 1'b1;
      cpu_uds_n = 1'b1;
      cpu_lds_n = 1'b1;
      tick();
      check("abort.no_handshake", 32'({dtack_n, berr_n, vpa_n}), 32'(3'b111));
      io_ack   = 1'b1;
      io_rdata = 16'hBEEF;
      tick();
      io_ack   = 1'b0;
      tick();
      check("abort.late_ack_hs", 32'({dtack_n, berr_n, vpa_n}), 32'(3'b111));
      check("abort.cpu_din", 32'(cpu_din), 32'h5A5A);
      check("abort.io_req_cycles", 32'(req_cycles - req0), 32'd1);
      run_vec(7);                               // responder is back in IDLE

      // TAS: read, strobes rise with AS low, then a write phase.
      we0       = we_cycles;
      cpu_a     = 23'h000100;                   // byte address 0x000200
      cpu_fc    = 3'd5;
      cpu_rw    = 1'b1;
      cpu_uds_n = 1'b0;
      cpu_lds_n = 1'b0;
      cpu_as_n  = 1'b0;
      tick();                                   // E0 (read)
      tick();
      check("tas.rd_dtack_e1", 32'(dtack_n), 32'd1);
      tick();
      check("tas.rd_dtack_e2", 32'(dtack_n), 32'd0);
      check("tas.rd_din", 32'(cpu_din), 32'h00C3);
      cpu_uds_n = 1'b1;
      cpu_lds_n = 1'b1;
      tick();
      check("tas.gap_release", 32'(dtack_n), 32'd1);
      cpu_rw    = 1'b0;
      cpu_dout  = 16'h0080;
      cpu_lds_n = 1'b0;
      tick();                                   // E0 (write)
      check("tas.wr_ram_we", 32'(ram_we), 32'(2'b01));
      tick();
      check("tas.wr_dtack_e1", 32'(dtack_n), 32'd1);
      tick();
      check("tas.wr_dtack_e2", 32'(dtack_n), 32'd0);
      cpu_as_n  = 1'b1;
      cpu_lds_n = 1'b1;
      cpu_rw    = 1'b1;
      tick();
      check("tas.wr_release", 32'(dtack_n), 32'd1);
      tick();
      check("tas.ram_we_cycles", 32'(we_cycles - we0), 32'd1);
      check("tas.mem_word", 32'(mem[14'h100]), 32'h0080);

      // Reset while TERM holds VPA low.
      cpu_a     = 23'h7FFFF9;
      cpu_fc    = 3'd7;
      cpu_lds_n = 1'b0;
      cpu_as_n  = 1'b0;
      tick();                                   // E0
      tick();
      check("rst_term.vpa_low", 32'(vpa_n), 32'd0);
      reset = 1'b1;
      tick();
      check("rst_term.handshakes", 32'({dtack_n, berr_n, vpa_n}), 32'(3'b111));
      check("rst_term.cpu_din", 32'(cpu_din), 32'h0);
      reset     = 1'b0;
      cpu_as_n  = 1'b1;
      cpu_lds_n = 1'b1;
      cpu_fc    = 3'd5;
      tick();
      check("rst_term.after", 32'({dtack_n, berr_n, vpa_n}), 32'(3'b111));
      run_vec(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
